mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Two-requester arbiter sharing the core's single memory bus between instruction fetch (port 0) and load/store (port 1).
- Accepts one request at a time on a valid/ready handshake and registers its payload.
- Drives the request onto the bus and holds the grant until the bus response returns, then routes the response to the owning requester.
- Sits between the IF and MEM pipeline stages and the memory/bus interface.

Parameters:
AW, 32, address width
DW, 32, data width
RR, 1, 1 = round-robin on ties; 0 = fixed priority with port 1 (LSU) winning

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid_i  in  2  per-port request valid (bit 0 = IF, bit 1 = LSU)
req_ready_o  out  2  per-port request accepted this cycle
req_addr_i  in  2*AW  per-port address, port n at bits [n*AW +: AW]
req_wdata_i  in  2*DW  per-port write data
req_we_i  in  2  per-port write enable
req_wstrb_i  in  2*(DW/8)  per-port byte strobes
resp_valid_o  out  2  one-cycle response pulse to the owning port
resp_rdata_o  out  DW  response data, shared by both ports
m_valid_o  out  1  bus request valid
m_ready_i  in  1  bus accepts request
m_addr_o  out  AW  registered address
m_wdata_o  out  DW  registered write data
m_we_o  out  1  registered write enable
m_wstrb_o  out  DW/8  registered byte strobes
m_rvalid_i  in  1  bus response valid; also returned for writes
m_rdata_i  in  DW  bus response data

Behaviour:
- Only one transaction is outstanding. FSM states: IDLE, ISSUE, WAIT.
- Reset (rst_n low, async):
  - state = IDLE; last_gnt = 1, so the first tie goes to port 0.
  - m_valid_o, resp_valid_o, m_we_o = 0; m_addr_o, m_wdata_o, m_wstrb_o, resp_rdata_o = 0.
- IDLE:
  - Winner is chosen combinationally from req_valid_i.
  - Single valid port: that port wins.
  - Both valid, RR=1: the port != last_gnt wins.
  - Both valid, RR=0: port 1 wins.
  - req_ready_o = one-hot of the winner; 0 if there is no valid request. Never asserted outside IDLE.
  - On acceptance: register the winner's addr/wdata/we/wstrb into the m_* registers, owner = winner, last_gnt = winner, go to ISSUE.
- ISSUE:
  - m_valid_o = 1 with a stable payload until m_ready_i.
  - On m_valid_o & m_ready_i: m_valid_o falls next cycle, go to WAIT.
  - Requester inputs are ignored in this state.
- WAIT:
  - m_valid_o = 0.
  - On m_rvalid_i: resp_valid_o[owner] = 1 for exactly one cycle (registered, next edge) and resp_rdata_o = m_rdata_i (registered), go to IDLE.
  - resp_rdata_o holds its value until the next response.
- Latency:
  - Accept at cycle 0; m_valid_o at cycle 1.
  - Response visible at cycle r+1 when m_rvalid_i arrives at cycle r.
  - The next acceptance can occur in that same cycle r+1.
  - Back-to-back throughput is one transaction per (bus latency + 2) cycles.
- Boundary conditions:
  - m_rvalid_i in IDLE or ISSUE: ignored; no resp_valid_o.
  - m_ready_i while m_valid_o = 0: ignored.
  - A requester may drop req_valid_i before acceptance with no side effect.
  - A request present in the cycle resp_valid_o pulses is eligible for arbitration in that same cycle.
  - Under RR=1, a port that is continuously valid is granted at least every second transaction (no starvation). Under RR=0, port 0 may starve.
  - rst_n asserted mid-transaction: the transaction is abandoned and all outputs return to reset values immediately. No response is delivered after reset.
  - resp_valid_o is never two-hot; req_ready_o is never two-hot.

Test Plan:
- Single IF read: port 0 addr 0x100, m_ready_i same cycle, m_rvalid_i 2 cycles later with 0xDEADBEEF -> req_ready_o=01 at cycle 0; m_valid_o with addr 0x100 at cycle 1; resp_valid_o=01 with rdata 0xDEADBEEF at cycle 4.
- Tie with RR=1, both continuously valid, 4 transactions -> grant order 0,1,0,1. With RR=0 -> order 1,1,1,1.
- Bus backpressure: m_ready_i held low 5 cycles while the requester changes addr from 0x200 to 0x300 after acceptance -> m_valid_o stays 1 for 6 cycles with m_addr_o=0x200.
- LSU write: port 1, we=1, wdata 0x12345678, wstrb 0011 -> m_we_o=1, m_wstrb_o=0011, m_wdata_o=0x12345678; resp_valid_o=10 on m_rvalid_i.
- Spurious m_rvalid_i in IDLE and in ISSUE -> no resp_valid_o; the transaction in flight still completes normally.
- rst_n pulsed low during WAIT -> m_valid_o=0 and resp_valid_o=0 immediately; a later m_rvalid_i produces no response; the next tie goes to port 0.

Source files
------------

// File: rtl/mem_port_arb_if.sv
// Request/response and memory-bus signal bundle for mem_port_arb.
// slave is the arbiter's view; master is the view of the requesters and the bus.
interface mem_port_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [2*AW-1:0] req_addr_i;
  logic [2*DW-1:0] req_wdata_i;
  logic [1:0]      req_we_i;
  logic [2*SW-1:0] req_wstrb_i;
  logic [1:0]      resp_valid_o;
  logic [DW-1:0]   resp_rdata_o;

  logic            m_valid_o;
  logic            m_ready_i;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;
  logic            m_we_o;
  logic [SW-1:0]   m_wstrb_o;
  logic            m_rvalid_i;
  logic [DW-1:0]   m_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_wstrb_i,
    input  m_ready_i, m_rvalid_i, m_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o,
    output m_valid_o, m_addr_o, m_wdata_o, m_we_o, m_wstrb_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_wstrb_i,
    output m_ready_i, m_rvalid_i, m_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o,
    input  m_valid_o, m_addr_o, m_wdata_o, m_we_o, m_wstrb_o
  );
endinterface

// File: rtl/mem_port_arb.sv
// Arbitrates IF (port 0) and LSU (port 1) onto one memory bus, one transaction outstanding.
// Accept -> m_valid next cycle; response pulses one cycle after m_rvalid; requesters stall until the bus answers.
module mem_port_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter bit RR = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  mem_port_arb_if.slave bus
);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q;
  logic          last_gnt_q;
  logic          owner_q;
  logic          m_valid_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [SW-1:0] m_wstrb_q;
  logic [1:0]    resp_valid_q;
  logic [DW-1:0] resp_rdata_q;

  logic          any_vld;
  logic          win;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          we_d;
  logic [SW-1:0] wstrb_d;

  // On a tie, round-robin favours the port that did not win last time.
  always_comb begin
    any_vld = |bus.req_valid_i;
    win     = bus.req_valid_i[1];
    if (&bus.req_valid_i) begin
      win = RR ? ~last_gnt_q : 1'b1;
    end
  end

  assign addr_d  = win ? bus.req_addr_i[AW +: AW]  : bus.req_addr_i[0 +: AW];
  assign wdata_d = win ? bus.req_wdata_i[DW +: DW] : bus.req_wdata_i[0 +: DW];
  assign we_d    = win ? bus.req_we_i[1]           : bus.req_we_i[0];
  assign wstrb_d = win ? bus.req_wstrb_i[SW +: SW] : bus.req_wstrb_i[0 +: SW];

  assign bus.req_ready_o = (state_q == IDLE && any_vld) ? {win, ~win} : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      owner_q      <= 1'b0;
      m_valid_q    <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            m_addr_q   <= addr_d;
            m_wdata_q  <= wdata_d;
            m_we_q     <= we_d;
            m_wstrb_q  <= wstrb_d;
            owner_q    <= win;
            last_gnt_q <= win;
            m_valid_q  <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_ready_i) begin
            m_valid_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.m_rvalid_i) begin
            resp_valid_q <= owner_q ? 2'b10 : 2'b01;
            resp_rdata_q <= bus.m_rdata_i;
            state_q      <= IDLE;
          end
        end
        default: begin
          m_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_valid_o    = m_valid_q;
  assign bus.m_addr_o     = m_addr_q;
  assign bus.m_wdata_o    = m_wdata_q;
  assign bus.m_we_o       = m_we_q;
  assign bus.m_wstrb_o    = m_wstrb_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a round-robin and a fixed-priority instance share identical stimulus,
// each checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [SW-1:0] wstrb;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      req_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_we;
  logic [2*SW-1:0] req_wstrb;
  logic            m_ready;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;

  mem_port_arb_if #(.AW(AW), .DW(DW)) if_rr ();
  mem_port_arb_if #(.AW(AW), .DW(DW)) if_fp ();

  assign if_rr.req_valid_i = req_valid;
  assign if_rr.req_addr_i  = req_addr;
  assign if_rr.req_wdata_i = req_wdata;
  assign if_rr.req_we_i    = req_we;
  assign if_rr.req_wstrb_i = req_wstrb;
  assign if_rr.m_ready_i   = m_ready;
  assign if_rr.m_rvalid_i  = m_rvalid;
  assign if_rr.m_rdata_i   = m_rdata;
  assign if_fp.req_valid_i = req_valid;
  assign if_fp.req_addr_i  = req_addr;
  assign if_fp.req_wdata_i = req_wdata;
  assign if_fp.req_we_i    = req_we;
  assign if_fp.req_wstrb_i = req_wstrb;
  assign if_fp.m_ready_i   = m_ready;
  assign if_fp.m_rvalid_i  = m_rvalid;
  assign if_fp.m_rdata_i   = m_rdata;

  mem_port_arb #(.AW(AW), .DW(DW), .RR(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
  mem_port_arb #(.AW(AW), .DW(DW), .RR(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp.slave));

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [1:0]    o_ready [2];
  logic [1:0]    o_resp  [2];
  logic [DW-1:0] o_rdata [2];
  logic          o_mvld  [2];
  logic [AW-1:0] o_maddr [2];
  logic [DW-1:0] o_mwdata[2];
  logic          o_mwe   [2];
  logic [SW-1:0] o_mwstrb[2];

  assign o_ready[0]  = if_rr.req_ready_o;   assign o_ready[1]  = if_fp.req_ready_o;
  assign o_resp[0]   = if_rr.resp_valid_o;  assign o_resp[1]   = if_fp.resp_valid_o;
  assign o_rdata[0]  = if_rr.resp_rdata_o;  assign o_rdata[1]  = if_fp.resp_rdata_o;
  assign o_mvld[0]   = if_rr.m_valid_o;     assign o_mvld[1]   = if_fp.m_valid_o;
  assign o_maddr[0]  = if_rr.m_addr_o;      assign o_maddr[1]  = if_fp.m_addr_o;
  assign o_mwdata[0] = if_rr.m_wdata_o;     assign o_mwdata[1] = if_fp.m_wdata_o;
  assign o_mwe[0]    = if_rr.m_we_o;        assign o_mwe[1]    = if_fp.m_we_o;
  assign o_mwstrb[0] = if_rr.m_wstrb_o;     assign o_mwstrb[1] = if_fp.m_wstrb_o;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one transaction record per instance, tracked by whether it is
  // outstanding and whether the bus still has to take it.
  bit            busy   [2];
  bit            on_bus [2];
  int            owner  [2];
  int            last   [2];
  txn_t          cur    [2];
  logic [1:0]    e_resp [2];
  logic [DW-1:0] e_rdata[2];
  int            miss   [2];
  int            gnt_q  [2][$];

  function automatic int pick(input int k);
    if (req_valid == 2'b00) return -1;
    if (req_valid == 2'b11) return (k == 0) ? 1 - last[k] : 1;
    return req_valid[1] ? 1 : 0;
  endfunction

  function automatic txn_t payload(input int p);
    txn_t t;
    t.addr  = req_addr[p*AW +: AW];
    t.wdata = req_wdata[p*DW +: DW];
    t.we    = req_we[p];
    t.wstrb = req_wstrb[p*SW +: SW];
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; on_bus[k] = 0; owner[k] = 0; last[k] = 1;
      cur[k] = '0; e_resp[k] = 2'b00; e_rdata[k] = '0;
      miss[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_addr = '0; req_wdata = '0; req_we = 2'b00; req_wstrb = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // Called at a negedge with inputs set; checks outputs, advances the model, returns at next negedge.
  task automatic step();
    int   w;
    string pre;
    #1;
    for (int k = 0; k < 2; k++) begin
      pre = (k == 0) ? "rr." : "fp.";
      w = busy[k] ? -1 : pick(k);
      chk({pre, "req_ready"}, 64'(o_ready[k]), (w < 0) ? 64'd0 : (64'd1 << w));
      chk({pre, "m_valid"}, 64'(o_mvld[k]), 64'(on_bus[k]));
      if (on_bus[k]) begin
        chk({pre, "m_addr"},  64'(o_maddr[k]),  64'(cur[k].addr));
        chk({pre, "m_wdata"}, 64'(o_mwdata[k]), 64'(cur[k].wdata));
        chk({pre, "m_we"},    64'(o_mwe[k]),    64'(cur[k].we));
        chk({pre, "m_wstrb"}, 64'(o_mwstrb[k]), 64'(cur[k].wstrb));
      end
      chk({pre, "resp_valid"}, 64'(o_resp[k]),  64'(e_resp[k]));
      chk({pre, "resp_rdata"}, 64'(o_rdata[k]), 64'(e_rdata[k]));
      if (o_ready[k] != 2'b00) gnt_q[k].push_back(o_ready[k][1] ? 1 : 0);
      if (k == 0) begin
        for (int p = 0; p < 2; p++) if (!req_valid[p]) miss[p] = 0;
        if (o_ready[0] != 2'b00) begin
          for (int p = 0; p < 2; p++) begin
            if (o_ready[0][p]) miss[p] = 0;
            else if (req_valid[p]) miss[p]++;
            chk("rr.no_starve", 64'(miss[p] > 1), 64'd0);
          end
        end
      end
      e_resp[k] = 2'b00;
      if (w >= 0) begin
        busy[k] = 1; on_bus[k] = 1; cur[k] = payload(w); owner[k] = w; last[k] = w;
      end else if (on_bus[k] && m_ready) begin
        on_bus[k] = 0;
      end else if (busy[k] && !on_bus[k] && m_rvalid) begin
        busy[k] = 0; e_resp[k] = 2'b01 << owner[k]; e_rdata[k] = m_rdata;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst.m_valid",    64'(o_mvld[k]),   64'd0);
      chk("rst.resp_valid", 64'(o_resp[k]),   64'd0);
      chk("rst.m_we",       64'(o_mwe[k]),    64'd0);
      chk("rst.m_addr",     64'(o_maddr[k]),  64'd0);
      chk("rst.m_wdata",    64'(o_mwdata[k]), 64'd0);
      chk("rst.m_wstrb",    64'(o_mwstrb[k]), 64'd0);
      chk("rst.resp_rdata", 64'(o_rdata[k]),  64'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    apply_reset();

    // Single IF read.
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h100; m_ready = 1'b1;
    #1 chk("t1.ready", 64'(o_ready[0]), 64'h1);
    step();
    req_valid = 2'b00;
    #1 chk("t1.m_valid", 64'(o_mvld[0]), 64'h1);
    chk("t1.m_addr", 64'(o_maddr[0]), 64'h100);
    step();
    m_ready = 1'b0; step();
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; step();
    m_rvalid = 1'b0; m_rdata = '0;
    #1 chk("t1.resp_valid", 64'(o_resp[0]), 64'h1);
    chk("t1.resp_rdata", 64'(o_rdata[0]), 64'hDEADBEEF);
    step();

    // Continuous tie: round-robin alternates, fixed priority always picks the LSU.
    apply_reset();
    gnt_q[0].delete(); gnt_q[1].delete();
    req_valid = 2'b11; req_addr = {32'h2000, 32'h1000}; m_ready = 1'b1; m_rvalid = 1'b1;
    for (int i = 0; i < 40 && gnt_q[0].size() < 4; i++) step();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
    chk("tie.rr_count", 64'(gnt_q[0].size()), 64'd4);
    chk("tie.fp_count", 64'(gnt_q[1].size()), 64'd4);
    if (gnt_q[0].size() >= 4 && gnt_q[1].size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("tie.rr_order", 64'(gnt_q[0][i]), 64'(i % 2));
        chk("tie.fp_order", 64'(gnt_q[1][i]), 64'd1);
      end
    end

    // Bus backpressure with a requester changing its address after acceptance.
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h200; step();
    req_addr[0 +: AW] = 32'h300;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      m_ready = (i == 5);
      if (i == 6) req_valid = 2'b00;
      #1;
      if (o_mvld[0]) begin
        cnt++;
        chk("bp.m_addr", 64'(o_maddr[0]), 64'h200);
      end
      step();
    end
    chk("bp.cycles", 64'(cnt), 64'd6);
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5A5A5; step();
    idle_inputs(); step();

    // LSU write.
    req_valid = 2'b10; req_we = 2'b10; req_wdata[DW +: DW] = 32'h12345678;
    req_wstrb[SW +: SW] = 4'b0011; req_addr[AW +: AW] = 32'h4000; m_ready = 1'b1;
    step();
    idle_inputs(); m_ready = 1'b1;
    #1 chk("wr.m_we", 64'(o_mwe[0]), 64'h1);
    chk("wr.m_wstrb", 64'(o_mwstrb[0]), 64'h3);
    chk("wr.m_wdata", 64'(o_mwdata[0]), 64'h12345678);
    step();
    m_ready = 1'b0; m_rvalid = 1'b1; step();
    m_rvalid = 1'b0;
    #1 chk("wr.resp_valid", 64'(o_resp[0]), 64'h2);
    step();

    // Spurious m_rvalid in IDLE and ISSUE.
    m_rvalid = 1'b1; m_rdata = 32'h0BAD0BAD; step();
    #1 chk("sp.idle_resp", 64'(o_resp[0]), 64'h0);
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h500; step();
    req_valid = 2'b00; step();
    #1 chk("sp.issue_resp", 64'(o_resp[0]), 64'h0);
    m_ready = 1'b1; step();
    m_ready = 1'b0; m_rvalid = 1'b0;
    #1 chk("sp.wait_resp", 64'(o_resp[0]), 64'h0);
    step();
    m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; step();
    m_rvalid = 1'b0;
    #1 chk("sp.resp_valid", 64'(o_resp[0]), 64'h1);
    chk("sp.resp_rdata", 64'(o_rdata[0]), 64'hCAFEF00D);
    step();

    // Reset during WAIT abandons the transaction.
    req_valid = 2'b10; req_addr[AW +: AW] = 32'h600; m_ready = 1'b1; step();
    req_valid = 2'b00; step();
    m_ready = 1'b0; step();
    m_rvalid = 1'b1; m_rdata = 32'h11111111;
    apply_reset();
    step();
    m_rvalid = 1'b0;
    #1 chk("rw.no_resp", 64'(o_resp[0]), 64'h0);
    step();
    req_valid = 2'b11;
    #1 chk("rw.tie_rr", 64'(o_ready[0]), 64'h1);
    chk("rw.tie_fp", 64'(o_ready[1]), 64'h2);
    step();
    idle_inputs();
    for (int i = 0; i < 2; i++) step();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) if ($urandom_range(0, 4) == 0) req_valid[p] = ~req_valid[p];
      req_addr  = {$urandom(), $urandom()};
      req_wdata = {$urandom(), $urandom()};
      req_we    = 2'($urandom());
      req_wstrb = 8'($urandom());
      m_ready   = ($urandom_range(0, 2) != 0);
      m_rvalid  = ($urandom_range(0, 2) == 0);
      m_rdata   = $urandom();
      if ($urandom_range(0, 299) == 0) apply_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
